// File: rtl/spi_arbiter.sv
// spi_arbiter: round-robin sequencer sharing one spi_master among NUM_REQ requesters.
// Define SPI_ARB_TIMEOUT_EN to add a WAIT-state watchdog that completes a stalled transfer with err.
module spi_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int ID_W           = $clog2(NUM_REQ),
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [8*NUM_REQ-1:0] req_tx_data,
    output logic [NUM_REQ-1:0]   ack,
    output logic [7:0]           rx_data,
    output logic                 err,
    output logic                 busy,
    output logic [ID_W-1:0]      grant_id,
    output logic [NUM_REQ-1:0]   slave_sel,
    output logic                 spi_start,
    output logic [7:0]           spi_tx_data,
    input  logic [7:0]           spi_rx_data,
    input  logic                 spi_done
);

    typedef enum logic [1:0] {IDLE, START, WAIT, DONE} state_t;

    state_t          state;
    logic [ID_W-1:0] ptr;
    logic [ID_W-1:0] winner;
    logic            any_req;
    logic [7:0]      tx_byte [NUM_REQ];

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 2) begin : g_param_check
        $error("spi_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYCLES at least 2");
    end

    // Rotating priority: first asserted request at or after ptr wins.
    always_comb begin
        logic [ID_W-1:0] idx;
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        idx     = '0;
        winner  = '0;
        any_req = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            tx_byte[i] = req_tx_data[8*i +: 8];
            idx        = ID_W'((int'(ptr) + i) % NUM_REQ);
            if (!any_req && req[idx]) begin
                winner  = idx;
                any_req = 1'b1;
            end
        end
    end

    assign busy = (state != IDLE);

`ifdef SPI_ARB_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0] watchdog;
`else
    assign err = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            ptr         <= '0;
            ack         <= '0;
            rx_data     <= '0;
            grant_id    <= '0;
            slave_sel   <= '0;
            spi_start   <= 1'b0;
            spi_tx_data <= '0;
`ifdef SPI_ARB_TIMEOUT_EN
            err         <= 1'b0;
            watchdog    <= '0;
`endif
        end else begin
            // NOTE: state registers use non-blocking assignments so every branch sees pre-edge values.
            case (state)
                IDLE: begin
                    if (any_req) begin
                        grant_id    <= winner;
                        spi_tx_data <= tx_byte[winner];
                        slave_sel   <= NUM_REQ'(1) << winner;
                        spi_start   <= 1'b1;
                        state       <= START;
                    end
                end
                START: begin
                    spi_start <= 1'b0;
                    state     <= WAIT;
`ifdef SPI_ARB_TIMEOUT_EN
                    watchdog  <= '0;
`endif
                end
                WAIT: begin
                    if (spi_done) begin
                        rx_data <= spi_rx_data;
                        ack     <= NUM_REQ'(1) << grant_id;
                        state   <= DONE;
                    end
`ifdef SPI_ARB_TIMEOUT_EN
                    // Watchdog value j is seen in the j-th WAIT cycle, so expiry lands TIMEOUT_CYCLES after entry.
                    else if (watchdog == WD_W'(TIMEOUT_CYCLES - 1)) begin
                        rx_data <= 8'h00;
                        ack     <= NUM_REQ'(1) << grant_id;
                        err     <= 1'b1;
                        state   <= DONE;
                    end else begin
                        watchdog <= watchdog + 1'b1;
                    end
`endif
                end
                DONE: begin
                    ack       <= '0;
                    slave_sel <= '0;
                    ptr       <= (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
                    state     <= IDLE;
`ifdef SPI_ARB_TIMEOUT_EN
                    err       <= 1'b0;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
